// File: rtl/sn_gen_scheduler.sv
// rtl/sn_gen_scheduler.sv - round-robin arbiter sharing one 4-lane stochastic-number generator
// Define SN_SCHED_PRIO_EN to give requester 0 strict priority over the round-robin ring.
module sn_gen_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LANES   = 4,
    parameter int DATA_W  = 4,
    parameter int SN_LEN  = 16,
    parameter int WDOG    = 4,
    localparam int ID_W   = $clog2(NUM_REQ),
    localparam int GW     = LANES * DATA_W
) (
    input  logic                    i_clk_sn_sched,
    input  logic                    i_rst_sn_sched,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ*GW-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic                    i_abort,
    output logic [GW-1:0]           o_gen_x_bn,
    output logic                    o_gen_start,
    output logic                    o_gen_stop,
    input  logic                    i_gen_isgen,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [ID_W-1:0]         o_done_id,
    output logic                    o_done_aborted
);

    localparam int CNT_W = $clog2(SN_LEN + WDOG + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [GW-1:0]      x_q, x_d;
    logic               ab_q, ab_d;
    logic               stopped_q, stopped_d;
    logic               stop_q, stop_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic               done_ab_q, done_ab_d;

    logic [NUM_REQ-1:0] arb_cand;
    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    arb_sel;
    logic [GW-1:0]      grant_data;
    logic               grant_any;
    int                 arb_idx;

    // Search starts one past the last grant and wraps, so every requester gets a turn.
    always_comb begin
        grant_oh   = '0;
        grant_id   = '0;
        grant_any  = 1'b0;
        grant_data = '0;
        arb_idx    = 0;
        arb_sel    = '0;
        arb_cand   = i_req_valid;
`ifdef SN_SCHED_PRIO_EN
        if (i_req_valid[0]) begin
            grant_oh[0] = 1'b1;
            grant_any   = 1'b1;
            arb_cand    = '0;
        end else begin
            arb_cand[0] = 1'b0;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = int'(last_q) + 1 + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            arb_sel = ID_W'(arb_idx);
            if (!grant_any && arb_cand[arb_sel]) begin
                grant_any         = 1'b1;
                grant_oh[arb_sel] = 1'b1;
                grant_id          = arb_sel;
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_oh[r]) grant_data = i_req_data[r*GW +: GW];
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        x_d       = x_q;
        ab_d      = ab_q;
        stopped_d = stopped_q;
        stop_d    = 1'b0;
        cnt_d     = cnt_q;
        done_id_d = done_id_q;
        done_ab_d = done_ab_q;
        case (state_q)
            S_IDLE: if (grant_any) begin
                x_d       = grant_data;
                id_d      = grant_id;
`ifdef SN_SCHED_PRIO_EN
                if (grant_id != '0) last_d = grant_id;
`else
                last_d    = grant_id;
`endif
                ab_d      = 1'b0;
                stopped_d = 1'b0;
                state_d   = S_LAUNCH;
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_gen_isgen) begin
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end else if (cnt_q == CNT_W'(WDOG - 1)) begin
                    ab_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (!i_gen_isgen) begin
                    state_d = S_DONE;
                end else if (stopped_q) begin
                    // Generator ignored the stop: give it WDOG cycles, then release the slot.
                    if (cnt_q == CNT_W'(WDOG - 1)) state_d = S_DONE;
                    else cnt_d = cnt_q + 1'b1;
                end else if (i_abort || cnt_q == CNT_W'(SN_LEN + WDOG)) begin
                    stop_d    = 1'b1;
                    stopped_d = 1'b1;
                    ab_d      = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_DONE && state_d == S_DONE) begin
            done_id_d = id_q;
            done_ab_d = ab_d;
        end
    end

    always_ff @(posedge i_clk_sn_sched or posedge i_rst_sn_sched) begin
        if (i_rst_sn_sched) begin
            state_q   <= S_IDLE;
            last_q    <= ID_W'(NUM_REQ - 1);
            id_q      <= '0;
            x_q       <= '0;
            ab_q      <= 1'b0;
            stopped_q <= 1'b0;
            stop_q    <= 1'b0;
            cnt_q     <= '0;
            done_id_q <= '0;
            done_ab_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            x_q       <= x_d;
            ab_q      <= ab_d;
            stopped_q <= stopped_d;
            stop_q    <= stop_d;
            cnt_q     <= cnt_d;
            done_id_q <= done_id_d;
            done_ab_q <= done_ab_d;
        end
    end

    assign o_req_ready    = (state_q == S_IDLE) ? grant_oh : '0;
    assign o_gen_x_bn     = x_q;
    assign o_gen_start    = (state_q == S_LAUNCH);
    assign o_gen_stop     = stop_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = (state_q == S_DONE);
    assign o_done_id      = done_id_q;
    assign o_done_aborted = done_ab_q;

endmodule
